oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Bus initiator for sprite DMA ($4014). A CPU write of page P starts a copy of XFER_LEN bytes
//  from CPU memory P*256.. into the PPU register interface. Each byte is one write strobe on
//  OAMDATA (reg 4); the interface auto-increments its OAM address. Sits between the CPU bus
//  decoder, the CPU RAM read port and the PPU register bus. It holds the CPU halted while busy.
// PARAMETERS
//  XFER_LEN      256  bytes per DMA; range 1..256
//  MEM_LAT       1    cycles from mem_rd to a valid mem_rdata; minimum 1
//  ALIGN_CYCLES  1    idle cycles after the trigger, before the first read (CPU dummy cycle)
// PORTS
//  clk           in   1   system clock; all logic on posedge
//  reset         in   1   asynchronous, active-high
//  dma_start     in   1   one-cycle pulse: CPU wrote $4014
//  dma_page      in   8   data of the $4014 write = source page
//  mem_addr      out  16  CPU memory read address
//  mem_rd        out  1   read request, one cycle per byte
//  mem_rdata     in   8   read data, valid MEM_LAT cycles after mem_rd
//  ppu_cs_n      out  1   PPU register chip select, active low; a falling edge = one access
//  ppu_we        out  1   1 = write access
//  ppu_reg_addr  out  3   PPU register number
//  ppu_wdata     out  8   PPU register write data
//  bus_grant     out  1   1 = top-level mux routes this block's ppu_* outputs, not the CPU's
//  cpu_rdy       out  1   0 = CPU halted
//  dma_busy      out  1   transfer in progress
//  dma_done      out  1   one-cycle pulse after the final strobe is released
// BEHAVIOUR
//  Reset values: all outputs 0, except ppu_cs_n=1 and cpu_rdy=1. State = IDLE. Counters = 0.
//  States:
//   IDLE: on dma_start, latch page, set cnt=0, go to ALIGN.
//    cpu_rdy=0, dma_busy=1 and bus_grant=1 from the next cycle.
//   ALIGN: stay ALIGN_CYCLES cycles, then go to RD.
//    If ALIGN_CYCLES=0, go directly from IDLE to RD.
//   RD: mem_rd=1, mem_addr={page,cnt[7:0]} (one cycle), then go to WAIT.
//   WAIT: stay MEM_LAT cycles. In the last cycle, latch mem_rdata into ppu_wdata. Go to STB.
//   STB: ppu_cs_n=0, ppu_we=1, ppu_reg_addr=3'd4 for exactly one cycle. Go to REL.
//   REL: ppu_cs_n=1, ppu_we=0 (one cycle). This guarantees a high cycle before the next edge.
//    If cnt==XFER_LEN-1, go to DONE. Otherwise cnt+=1 and go to RD.
//   DONE: dma_done=1 (one cycle). cpu_rdy=1, dma_busy=0, bus_grant=0. Go to IDLE.
//  Per-byte latency: 3+MEM_LAT cycles.
//   Total, trigger to dma_done: 1+ALIGN_CYCLES+XFER_LEN*(3+MEM_LAT) cycles.
//   For the defaults this is 1026.
//  cnt is 9 bits. mem_addr low byte = cnt[7:0]; the page never increments (no carry across pages).
//  ppu_reg_addr holds 3'd4 throughout a transfer. ppu_wdata holds its value outside STB.
//  dma_start while dma_busy: ignored. The transfer is not restarted and dma_page is not re-latched.
//  dma_start in the same cycle as dma_done: ignored. The next trigger is accepted in IDLE.
//  Asynchronous reset mid-transfer: immediate IDLE, ppu_cs_n=1, cpu_rdy=1, no dma_done.
//   The partial OAM contents are left as written.
//  ppu_cs_n must never be low for two consecutive cycles, and never low outside STB.
// STRUCTURE
//  Shared package ppu_pkg holds:
//   - PPU register numbers: PPUCTRL=0, PPUMASK=1, PPUSTATUS=2, OAMADDR=3, OAMDATA=4,
//     PPUSCROLL=5, PPUADDR=6, PPUDATA=7
//   - dma_state_t enum {IDLE,ALIGN,RD,WAIT,STB,REL,DONE}
//   - DMA_REG_ADDR = 16'h4014
//  Single module: one FSM plus a byte counter and a wait counter. No sub-module.
// TESTING
//  1. Page 8'h02, mem[i]=i^8'hA5. Expect 256 strobes with reg_addr=4, we=1, data in order.
//     Expect dma_done 1026 cycles after dma_start.
//     Expect the OAM model (via the PPU register interface) to hold mem[0x200..0x2FF].
//  2. Second dma_start at cycle 100 of a transfer, page 8'h07.
//     Expect no change: same page, same total cycles, single dma_done.
//  3. Reset asserted at byte 37 during STB. Expect cs_n=1 and cpu_rdy=1 asynchronously.
//     Restart with page 8'h03: the count restarts at 0, mem_addr=16'h0300.
//  4. MEM_LAT=2, XFER_LEN=4, ALIGN_CYCLES=0.
//     Expect 5 cycles per byte, 21 cycles total, data sampled on the correct cycle.
//  5. Page 8'hFF, last byte. Expect mem_addr=16'hFFFF, then no wrap to 16'h0000.
//  6. Protocol assertions: cs_n low exactly 256 single cycles; cpu_rdy=0 for the whole busy window.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: shared PPU definitions for the sprite DMA block.
//   - PPU register numbers as seen on the 3-bit register bus
//   - dma_state_t: sprite DMA controller state encoding
//   - DMA_REG_ADDR: CPU address that triggers a sprite DMA
package ppu_pkg;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        RD,
        WAIT,
        STB,
        REL,
        DONE
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA bus initiator.
// A trigger with page P copies XFER_LEN bytes from CPU memory {P,00}.. into
// OAM through single write strobes on OAMDATA, holding the CPU halted while
// the transfer runs.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   dma_start/dma_page  one-cycle trigger and source page
//   mem_addr/mem_rd     CPU memory read request (one cycle per byte)
//   mem_rdata           read data, valid MEM_LAT cycles after mem_rd
//   ppu_cs_n/ppu_we/ppu_reg_addr/ppu_wdata   PPU register bus
//   bus_grant/cpu_rdy/dma_busy               arbitration / CPU halt
//   dma_done            one-cycle pulse after the last strobe is released
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter int XFER_LEN     = 256,
    parameter int MEM_LAT      = 1,
    parameter int ALIGN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        ppu_cs_n,
    output logic        ppu_we,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wdata,
    output logic        bus_grant,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam int WAIT_MAX = (MEM_LAT > ALIGN_CYCLES) ? MEM_LAT : ALIGN_CYCLES;
    localparam int WCW      = $clog2(WAIT_MAX + 1);

    dma_state_t     r_state;
    logic [7:0]     r_page;
    logic [8:0]     r_cnt;
    logic [WCW-1:0] r_wait;   // cycles left in ALIGN/WAIT; 0 = last cycle

    // All outputs are registered and set on the transition into the state
    // that owns them, so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_page       <= '0;
            r_cnt        <= '0;
            r_wait       <= '0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            ppu_cs_n     <= 1'b1;
            ppu_we       <= 1'b0;
            ppu_reg_addr <= '0;
            ppu_wdata    <= '0;
            bus_grant    <= 1'b0;
            cpu_rdy      <= 1'b1;
            dma_busy     <= 1'b0;
            dma_done     <= 1'b0;
        end else begin
            mem_rd   <= 1'b0;
            dma_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dma_start) begin
                        r_page       <= dma_page;
                        r_cnt        <= '0;
                        cpu_rdy      <= 1'b0;
                        dma_busy     <= 1'b1;
                        bus_grant    <= 1'b1;
                        ppu_reg_addr <= OAMDATA;
                        if (ALIGN_CYCLES == 0) begin
                            r_state  <= RD;
                            mem_rd   <= 1'b1;
                            mem_addr <= {dma_page, 8'h00};
                        end else begin
                            r_state <= ALIGN;
                            r_wait  <= WCW'(ALIGN_CYCLES - 1);
                        end
                    end
                end
                ALIGN: begin
                    if (r_wait == '0) begin
                        r_state  <= RD;
                        mem_rd   <= 1'b1;
                        mem_addr <= {r_page, r_cnt[7:0]};
                    end else begin
                        r_wait <= r_wait - WCW'(1);
                    end
                end
                RD: begin
                    r_state <= WAIT;
                    r_wait  <= WCW'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (r_wait == '0) begin
                        r_state   <= STB;
                        ppu_wdata <= mem_rdata;
                        ppu_cs_n  <= 1'b0;
                        ppu_we    <= 1'b1;
                    end else begin
                        r_wait <= r_wait - WCW'(1);
                    end
                end
                STB: begin
                    // Release for a full cycle so every byte gets its own falling edge.
                    r_state  <= REL;
                    ppu_cs_n <= 1'b1;
                    ppu_we   <= 1'b0;
                end
                REL: begin
                    if (r_cnt == 9'(XFER_LEN - 1)) begin
                        r_state   <= DONE;
                        dma_done  <= 1'b1;
                        cpu_rdy   <= 1'b1;
                        dma_busy  <= 1'b0;
                        bus_grant <= 1'b0;
                    end else begin
                        r_state  <= RD;
                        r_cnt    <= r_cnt + 9'd1;
                        mem_rd   <= 1'b1;
                        // Low byte wraps within the page; the page never carries.
                        mem_addr <= {r_page, r_cnt[7:0] + 8'd1};
                    end
                end
                DONE: begin
                    // A trigger coinciding with this cycle is dropped.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;
    import ppu_pkg::*;

    localparam int L0 = 256, M0 = 1, A0 = 1;
    localparam int L1 = 4,   M1 = 2, A1 = 0;
    localparam logic [1:0] K_RD = 2'd0, K_STB = 2'd1, K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        int          cyc;
        logic [15:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic [7:0]  page  [2];
    logic [15:0] maddr [2];
    logic        mrd   [2];
    logic [7:0]  rdata [2];
    logic        csn   [2];
    logic        we    [2];
    logic [2:0]  rega  [2];
    logic [7:0]  wd    [2];
    logic        grant [2];
    logic        rdy   [2];
    logic        busy  [2];
    logic        done  [2];

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];
    logic [7:0]  rp1 [2];
    logic [7:0]  rp2 [2];
    int          optr;
    int          cyc = 0;
    int          errors = 0, checks = 0;
    ev_t         q0[$], q1[$];
    int          mstart [2], mdone [2], lowcnt [2], done_at [2];
    logic        prevlow [2];

    oam_dma_ctrl #(.XFER_LEN(L0), .MEM_LAT(M0), .ALIGN_CYCLES(A0)) u_dut (
        .clk(clk), .reset(rst), .dma_start(start[0]), .dma_page(page[0]),
        .mem_addr(maddr[0]), .mem_rd(mrd[0]), .mem_rdata(rdata[0]),
        .ppu_cs_n(csn[0]), .ppu_we(we[0]), .ppu_reg_addr(rega[0]), .ppu_wdata(wd[0]),
        .bus_grant(grant[0]), .cpu_rdy(rdy[0]), .dma_busy(busy[0]), .dma_done(done[0])
    );

    oam_dma_ctrl #(.XFER_LEN(L1), .MEM_LAT(M1), .ALIGN_CYCLES(A1)) u_dut4 (
        .clk(clk), .reset(rst), .dma_start(start[1]), .dma_page(page[1]),
        .mem_addr(maddr[1]), .mem_rd(mrd[1]), .mem_rdata(rdata[1]),
        .ppu_cs_n(csn[1]), .ppu_we(we[1]), .ppu_reg_addr(rega[1]), .ppu_wdata(wd[1]),
        .bus_grant(grant[1]), .cpu_rdy(rdy[1]), .dma_busy(busy[1]), .dma_done(done[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CPU RAM: one registered stage per cycle of read latency.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            rp1[u] <= mrd[u] ? mem[maddr[u]] : 8'h00;
            rp2[u] <= rp1[u];
        end
    end
    assign rdata[0] = rp1[0];
    assign rdata[1] = rp2[1];

    function automatic int plen(input int u); return (u == 0) ? L0 : L1; endfunction
    function automatic int plat(input int u); return (u == 0) ? M0 : M1; endfunction
    function automatic int palg(input int u); return (u == 0) ? A0 : A1; endfunction
    function automatic int qn(input int u); return (u == 0) ? q0.size() : q1.size(); endfunction
    function automatic ev_t qf(input int u); return (u == 0) ? q0[0] : q1[0]; endfunction

    task automatic qpop(input int u);
        if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask

    task automatic qpush(input int u, input logic [1:0] k, input int c, input logic [15:0] v);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a trigger is taken only if the block is idle in the
    // cycle it is presented; the whole event sequence follows from the
    // per-byte budget of 3+MEM_LAT cycles.
    task automatic issue(input int u, input logic [7:0] p);
        int n, t;
        n = cyc;
        start[u] = 1'b1;
        page[u]  = p;
        if (n > mdone[u]) begin
            mstart[u] = n;
            lowcnt[u] = 0;
            if (u == 0) optr = 0;
            t = n + 1 + palg(u);
            for (int k = 0; k < plen(u); k++) begin
                qpush(u, K_RD, t, {p, 8'(k)});
                t = t + 1 + plat(u);
                qpush(u, K_STB, t, {4'b0, 1'b1, OAMDATA, mem[{p, 8'(k)}]});
                t = t + 2;
            end
            qpush(u, K_DONE, t, 16'h0);
            mdone[u] = t;
        end
        step();
        start[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int budget);
        int b;
        b = 0;
        while (qn(u) > 0 && b < budget) begin
            step();
            b++;
        end
        if (qn(u) > 0) begin
            chk("timeout_pending_events", qn(u), 0);
            while (qn(u) > 0) qpop(u);
        end
        step();
        step();
    endtask

    task automatic oam_cmp(input logic [7:0] p);
        for (int i = 0; i < 256; i++) chk("oam_contents", oam[i], mem[{p, 8'(i)}]);
    endtask

    task automatic mon_cycle();
        int   ne;
        logic [1:0]  k;
        logic [15:0] v;
        logic        eb;
        ev_t  e;
        for (int u = 0; u < 2; u++) begin
            ne = int'(mrd[u]) + int'(!csn[u]) + int'(done[u]);
            if (ne > 1) chk("one_event_per_cycle", ne, 1);
            k = mrd[u] ? K_RD : (!csn[u] ? K_STB : K_DONE);
            v = mrd[u] ? maddr[u] : (!csn[u] ? {4'b0, we[u], rega[u], wd[u]} : 16'h0);
            while (qn(u) > 0 && qf(u).cyc < cyc) begin
                chk("event_overdue", qf(u).cyc, cyc);
                qpop(u);
            end
            if (qn(u) > 0 && qf(u).cyc == cyc) begin
                e = qf(u);
                qpop(u);
                chk("event_present", (ne > 0), 1);
                if (ne > 0) begin
                    chk("event_kind", k, e.kind);
                    chk(k == K_RD ? "rd_addr" : "strobe_data", v, e.val);
                end
            end else if (ne > 0) begin
                chk("unexpected_event", {k, v}, 18'h3ffff);
            end
            if (!csn[u]) begin
                chk("cs_single_cycle", prevlow[u], 1'b0);
                lowcnt[u]++;
                if (u == 0 && we[u] && rega[u] == OAMDATA) begin
                    oam[optr[7:0]] = wd[u];
                    optr++;
                end
            end
            prevlow[u] = !csn[u];
            if (done[u]) begin
                done_at[u] = cyc;
                chk("strobe_count", lowcnt[u], plen(u));
            end
            eb = (cyc > mstart[u]) && (cyc < mdone[u]);
            chk("dma_busy", busy[u], eb);
            chk("cpu_rdy", rdy[u], !eb);
            chk("bus_grant", grant[u], eb);
        end
    endtask

    initial begin
        int n0;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; page[u] = 8'h00;
            mstart[u] = -1; mdone[u] = -1; lowcnt[u] = 0; done_at[u] = -1; prevlow[u] = 1'b0;
        end
        optr = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;

        fork
            begin : stim
                step(); step();
                for (int u = 0; u < 2; u++) begin
                    chk("rst_cs_n", csn[u], 1'b1);
                    chk("rst_cpu_rdy", rdy[u], 1'b1);
                    chk("rst_outputs_zero",
                        {maddr[u], mrd[u], we[u], rega[u], wd[u], grant[u], busy[u], done[u]}, '0);
                end
                rst = 1'b0;
                step();

                // Page 02 full transfer; trigger-to-done and OAM image.
                n0 = cyc;
                issue(0, 8'h02);
                wait_idle(0, 1200);
                chk("t1_total_cycles", done_at[0] - n0, 1026);
                oam_cmp(8'h02);

                // Retrigger with another page mid-transfer is ignored.
                n0 = cyc;
                issue(0, 8'h05);
                while (cyc < n0 + 100) step();
                issue(0, 8'h07);
                wait_idle(0, 1200);
                chk("t2_total_cycles", done_at[0] - n0, 1026);
                oam_cmp(8'h05);

                // Async reset during the strobe of byte 37, then restart.
                n0 = cyc;
                issue(0, 8'h10);
                while (cyc < n0 + 2 + A0 + M0 + 37 * (3 + M0)) step();
                chk("t3_in_strobe", csn[0], 1'b0);
                rst = 1'b1;
                #1;
                chk("t3_async_cs_n", csn[0], 1'b1);
                chk("t3_async_cpu_rdy", rdy[0], 1'b1);
                chk("t3_async_busy", {busy[0], grant[0], done[0]}, 3'b000);
                while (qn(0) > 0) qpop(0);
                mstart[0] = -1; mdone[0] = -1;
                step();
                rst = 1'b0;
                step();
                issue(0, 8'h03);
                wait_idle(0, 1200);

                // Last page: final address FFFF, no wrap afterwards.
                issue(0, 8'hFF);
                wait_idle(0, 1200);
                chk("t5_addr_no_wrap", maddr[0], 16'hFFFF);

                // Short transfers, latency 2, no align: random pages/gaps,
                // including triggers while busy and on the done cycle.
                n0 = cyc;
                issue(1, 8'h42);
                wait_idle(1, 100);
                chk("t4_total_cycles", done_at[1] - n0, 21);
                for (int it = 0; it < 40; it++) begin
                    issue(1, 8'($urandom));
                    repeat ($urandom_range(0, 24)) step();
                end
                wait_idle(1, 200);
            end
            forever begin
                @(negedge clk);
                if (!rst) mon_cycle();
                else begin
                    prevlow[0] = 1'b0;
                    prevlow[1] = 1'b0;
                end
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
